coop_pkt_tx: RTL and testbench

COOP_PKT_TX -- requirements
Module: coop_pkt_tx

---
 rtl/coop_pkt_tx.sv | 152 +++++++++++++++
 tb/tb_coop_pkt_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coop_pkt_tx.sv
// rtl/coop_pkt_tx.sv - framed field packet sender for a byte UART, with change detect and heartbeat resend
// Build option: define COOP_TX_CHECKSUM_EN to append an XOR checksum of the payload bytes.
module coop_pkt_tx #(
    parameter int         NUM_FIELDS       = 2,
    parameter int         FIELD_W          = 10,
    parameter logic [7:0] SYNC_BYTE        = 8'hAA,
    parameter int         HEARTBEAT_CYCLES = 65_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields_in,
    input  logic                          tx_busy,
    output logic [7:0]                    tx_data,
    output logic                          tx_wr,
    output logic                          pkt_busy,
    output logic                          pkt_sent
);

    localparam int BPF       = (FIELD_W + 7) / 8;
    localparam int PAY_BYTES = NUM_FIELDS * BPF;
`ifdef COOP_TX_CHECKSUM_EN
    localparam int PKT_LEN   = PAY_BYTES + 2;
`else
    localparam int PKT_LEN   = PAY_BYTES + 1;
`endif
    localparam int IDX_W     = $clog2(PKT_LEN);
    localparam int HB_W      = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES + 1) : 1;
    localparam logic [HB_W-1:0]  HB_MAX   = HB_W'(HEARTBEAT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT} state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [NUM_FIELDS*FIELD_W-1:0]   r_pkt;
    logic [NUM_FIELDS*FIELD_W-1:0]   r_last_sent;
    logic [IDX_W-1:0]                r_idx;
    logic [IDX_W-1:0]                w_idx_nxt;
    logic [HB_W-1:0]                 r_hb;
    logic [7:0]                      r_tx_data;
    logic                            r_tx_wr;
    logic                            r_pkt_busy;
    logic                            r_pkt_sent;
    logic [PAY_BYTES*8-1:0]          w_payload;
    logic [7:0]                      w_byte;
    logic                            w_hb_expired;
    logic                            w_trigger;
    logic                            w_start;
    logic                            w_last;
    logic                            w_done;
    logic                            w_sent_nxt;
    logic                            w_wr_nxt;
    logic                            w_busy_nxt;

    // Each field is zero-extended to a whole number of bytes, little-endian.
    always_comb begin
        w_payload = '0;
        for (int k = 0; k < NUM_FIELDS; k++)
            w_payload[k*BPF*8 +: FIELD_W] = r_pkt[k*FIELD_W +: FIELD_W];
    end

`ifdef COOP_TX_CHECKSUM_EN
    logic [7:0] w_cks;
    always_comb begin
        w_cks = '0;
        for (int b = 0; b < PAY_BYTES; b++)
            w_cks = w_cks ^ w_payload[b*8 +: 8];
    end
`endif

    always_comb begin
        w_byte = SYNC_BYTE;
        for (int b = 0; b < PAY_BYTES; b++)
            if (w_idx_nxt == IDX_W'(b + 1))
                w_byte = w_payload[b*8 +: 8];
`ifdef COOP_TX_CHECKSUM_EN
        if (w_idx_nxt == LAST_IDX)
            w_byte = w_cks;
`endif
    end

    assign w_hb_expired = (HEARTBEAT_CYCLES != 0) && (r_hb == HB_MAX);
    assign w_trigger    = (fields_in != r_last_sent) || w_hb_expired;
    assign w_start      = (r_state == S_IDLE) && w_trigger && !tx_busy;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_done       = (r_state == S_WAIT) && !tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SEND;
            S_SEND:  w_state_nxt = S_GUARD;
            // UART busy may rise a cycle after the strobe, so it is not sampled here.
            S_GUARD: w_state_nxt = S_WAIT;
            S_WAIT:  if (!tx_busy) w_state_nxt = w_last ? S_IDLE : S_SEND;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_idx_nxt  = r_idx;
        w_sent_nxt = 1'b0;
        if (w_start)
            w_idx_nxt = '0;
        else if (w_done && !w_last)
            w_idx_nxt = r_idx + 1'b1;
        if (w_done && w_last)
            w_sent_nxt = 1'b1;
        w_wr_nxt   = (w_state_nxt == S_SEND);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt       <= '0;
            r_last_sent <= '0;
            r_idx       <= '0;
            r_hb        <= '0;
            r_tx_data   <= '0;
            r_tx_wr     <= 1'b0;
            r_pkt_busy  <= 1'b0;
            r_pkt_sent  <= 1'b0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_tx_wr    <= w_wr_nxt;
            r_pkt_busy <= w_busy_nxt;
            r_pkt_sent <= w_sent_nxt;
            if (w_wr_nxt)
                r_tx_data <= w_byte;
            if (w_start) begin
                r_pkt       <= fields_in;
                r_last_sent <= fields_in;
                r_hb        <= '0;
            end else if ((r_state == S_IDLE) && !w_trigger && (r_hb != HB_MAX)) begin
                r_hb <= r_hb + 1'b1;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_wr    = r_tx_wr;
    assign pkt_busy = r_pkt_busy;
    assign pkt_sent = r_pkt_sent;

endmodule

// File: tb/tb_coop_pkt_tx.sv
// tb/tb_coop_pkt_tx.sv - directed bench for coop_pkt_tx (heartbeat off and heartbeat=100 instances)
module tb_coop_pkt_tx;
    localparam int NF  = 2;
    localparam int FW  = 10;
    localparam int W   = NF * FW;
    localparam int CAP = 4096;
`ifdef COOP_TX_CHECKSUM_EN
    localparam int PLEN = 6;
`else
    localparam int PLEN = 5;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] fields_in = '0;
    logic         tx_busy, tx_wr, pkt_busy, pkt_sent;
    logic [7:0]   tx_data;
    logic         hb_busy, hb_wr, hb_pkt_busy, hb_sent;
    logic [7:0]   hb_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_basic [6] = '{8'hAA, 8'h00, 8'h02, 8'h2C, 8'h01, 8'h2F};
    logic [7:0] exp_chg   [6] = '{8'hAA, 8'h07, 8'h00, 8'h2C, 8'h01, 8'h2A};
    logic [7:0] exp_late  [6] = '{8'hAA, 8'hFF, 8'h03, 8'h01, 8'h00, 8'hFD};
    logic [7:0] exp_force [6] = '{8'hAA, 8'h05, 8'h00, 8'h06, 8'h00, 8'h03};
    logic [7:0] exp_hb    [6] = '{8'hAA, 8'h08, 8'h00, 8'h09, 8'h00, 8'h01};
    logic [7:0] exp_rst   [6] = '{8'hAA, 8'hC3, 8'h03, 8'hF0, 8'h00, 8'h30};

    always #5 clk = ~clk;

    coop_pkt_tx #(.NUM_FIELDS(NF), .FIELD_W(FW), .SYNC_BYTE(8'hAA), .HEARTBEAT_CYCLES(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .fields_in(fields_in), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_wr(tx_wr), .pkt_busy(pkt_busy), .pkt_sent(pkt_sent));

    coop_pkt_tx #(.NUM_FIELDS(NF), .FIELD_W(FW), .SYNC_BYTE(8'hAA), .HEARTBEAT_CYCLES(100)) u_hb (
        .clk(clk), .rst_n(rst_n), .fields_in(fields_in), .tx_busy(hb_busy),
        .tx_data(hb_data), .tx_wr(hb_wr), .pkt_busy(hb_pkt_busy), .pkt_sent(hb_sent));

    // UART models: busy for 10 cycles per byte; late_mode raises busy one cycle later.
    int   busy_cnt, hb_cnt;
    logic wr_d;
    logic late_mode = 1'b0;
    logic force_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
            wr_d     <= 1'b0;
        end else begin
            wr_d <= tx_wr;
            if (late_mode ? wr_d : tx_wr) busy_cnt <= 10;
            else if (busy_cnt > 0)        busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = (busy_cnt != 0) || force_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          hb_cnt <= 0;
        else if (hb_wr)      hb_cnt <= 10;
        else if (hb_cnt > 0) hb_cnt <= hb_cnt - 1;
    end
    assign hb_busy = (hb_cnt != 0);

    int         cyc = 0, cap_n = 0, sent_n = 0, wr_viol = 0;
    int         hb_wr_n = 0, hb_sent_n = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] cap_mem [CAP];
    logic [7:0] hb_mem [CAP];
    int         hb_wr_cyc [CAP];
    int         hb_sent_cyc [CAP];

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_busy <= tx_busy;
        if (tx_wr) begin
            if (cap_n < CAP) cap_mem[cap_n] <= tx_data;
            cap_n <= cap_n + 1;
            if (prev_busy || tx_busy) wr_viol <= wr_viol + 1;
        end
        if (pkt_sent) sent_n <= sent_n + 1;
        if (hb_wr) begin
            if (hb_wr_n < CAP) begin
                hb_mem[hb_wr_n]    <= hb_data;
                hb_wr_cyc[hb_wr_n] <= cyc;
            end
            hb_wr_n <= hb_wr_n + 1;
        end
        if (hb_sent) begin
            if (hb_sent_n < CAP) hb_sent_cyc[hb_sent_n] <= cyc;
            hb_sent_n <= hb_sent_n + 1;
        end
    end

    task automatic wait_sent(input int target);
        int k = 0;
        while (sent_n < target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        int base;
        rst_n = 1'b0;
        fields_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (tx_wr !== 1'b0)    begin errors++; $display("FAIL reset_tx_wr got %b want 0", tx_wr); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL reset_pkt_busy got %b want 0", pkt_busy); end
        checks++; if (pkt_sent !== 1'b0) begin errors++; $display("FAIL reset_pkt_sent got %b want 0", pkt_sent); end
        base = cap_n;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (cap_n != base) begin errors++; $display("FAIL reset_idle_quiet got %0d strobes want 0", cap_n - base); end
    endtask

    task automatic test_basic();
        int base, sbase;
        base = cap_n; sbase = sent_n;
        fields_in = {10'd300, 10'd512};
        wait_sent(sbase + 1);
        checks++; if (sent_n != sbase + 1) begin errors++; $display("FAIL basic_sent got %0d want 1", sent_n - sbase); end
        checks++; if (cap_n - base != PLEN) begin errors++; $display("FAIL basic_len got %0d want %0d", cap_n - base, PLEN); end
        for (int i = 0; i < PLEN; i++) begin
            checks++;
            if (cap_mem[base+i] !== exp_basic[i]) begin
                errors++; $display("FAIL basic_byte%0d got %h want %h", i, cap_mem[base+i], exp_basic[i]);
            end
        end
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL basic_pkt_busy got %b want 0", pkt_busy); end
    endtask

    task automatic test_late_busy();
        int base, sbase;
        late_mode = 1'b1;
        base = cap_n; sbase = sent_n;
        fields_in = {10'd1, 10'd1023};
        wait_sent(sbase + 1);
        checks++; if (cap_n - base != PLEN) begin errors++; $display("FAIL late_len got %0d want %0d", cap_n - base, PLEN); end
        for (int i = 0; i < PLEN; i++) begin
            checks++;
            if (cap_mem[base+i] !== exp_late[i]) begin
                errors++; $display("FAIL late_byte%0d got %h want %h", i, cap_mem[base+i], exp_late[i]);
            end
        end
        late_mode = 1'b0;
    endtask

    task automatic test_force_busy();
        int base, sbase, k;
        force_busy = 1'b1;
        base = cap_n; sbase = sent_n;
        fields_in = {10'd6, 10'd5};
        repeat (40) @(negedge clk);
        checks++; if (cap_n != base)     begin errors++; $display("FAIL busy_hold_wr got %0d strobes want 0", cap_n - base); end
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL busy_hold_pkt_busy got %b want 0", pkt_busy); end
        force_busy = 1'b0;
        k = 0;
        while (!tx_wr && k < 5) begin
            @(negedge clk);
            k++;
        end
        checks++; if (!(tx_wr && k <= 2)) begin errors++; $display("FAIL busy_release_latency got %0d cycles want <=2", k); end
        checks++; if (tx_data !== 8'hAA)  begin errors++; $display("FAIL busy_release_sync got %h want aa", tx_data); end
        wait_sent(sbase + 1);
        for (int i = 0; i < PLEN; i++) begin
            checks++;
            if (cap_mem[base+i] !== exp_force[i]) begin
                errors++; $display("FAIL busy_byte%0d got %h want %h", i, cap_mem[base+i], exp_force[i]);
            end
        end
    endtask

    task automatic test_change_during();
        int base, sbase, seen, k;
        base = cap_n; sbase = sent_n;
        fields_in = {10'd300, 10'd512};
        seen = 0; k = 0;
        while (seen < 3 && k < 300) begin
            @(negedge clk);
            k++;
            if (tx_wr) seen++;
        end
        fields_in = {10'd300, 10'd7};
        wait_sent(sbase + 2);
        checks++; if (sent_n != sbase + 2)    begin errors++; $display("FAIL chg_sent got %0d want 2", sent_n - sbase); end
        checks++; if (cap_n - base != 2*PLEN) begin errors++; $display("FAIL chg_len got %0d want %0d", cap_n - base, 2*PLEN); end
        for (int i = 0; i < PLEN; i++) begin
            checks++;
            if (cap_mem[base+i] !== exp_basic[i]) begin
                errors++; $display("FAIL chg_first_byte%0d got %h want %h", i, cap_mem[base+i], exp_basic[i]);
            end
            checks++;
            if (cap_mem[base+PLEN+i] !== exp_chg[i]) begin
                errors++; $display("FAIL chg_second_byte%0d got %h want %h", i, cap_mem[base+PLEN+i], exp_chg[i]);
            end
        end
    endtask

    task automatic test_heartbeat();
        int k, bw, bs, sbase, gap;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!hb_sent && k < 400);
        fields_in = {10'd9, 10'd8};
        @(posedge clk);
        bw = hb_wr_n; bs = hb_sent_n; sbase = sent_n;
        k = 0;
        while (hb_sent_n < bs + 3 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        checks++; if (hb_sent_n < bs + 3) begin errors++; $display("FAIL hb_resends got %0d packets want 3", hb_sent_n - bs); end
        for (int j = 0; j < 2; j++) begin
            gap = hb_wr_cyc[bw + (j+1)*PLEN] - hb_sent_cyc[bs + j];
            checks++; if (gap != 101) begin errors++; $display("FAIL hb_gap%0d got %0d cycles want 101", j, gap); end
        end
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < PLEN; i++) begin
                checks++;
                if (hb_mem[bw + j*PLEN + i] !== exp_hb[i]) begin
                    errors++; $display("FAIL hb_pkt%0d_byte%0d got %h want %h", j, i, hb_mem[bw + j*PLEN + i], exp_hb[i]);
                end
            end
        checks++; if (sent_n != sbase + 1) begin errors++; $display("FAIL hb_disabled_sent got %0d want 1", sent_n - sbase); end
    endtask

    task automatic test_reset_mid();
        int base, sbase, seen, k;
        fields_in = {10'd240, 10'd963};
        seen = 0; k = 0;
        while (seen < 3 && k < 300) begin
            @(negedge clk);
            k++;
            if (tx_wr) seen++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data got %h want 00", tx_data); end
        checks++; if (tx_wr !== 1'b0)    begin errors++; $display("FAIL rstmid_tx_wr got %b want 0", tx_wr); end
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL rstmid_pkt_busy got %b want 0", pkt_busy); end
        checks++; if (pkt_sent !== 1'b0) begin errors++; $display("FAIL rstmid_pkt_sent got %b want 0", pkt_sent); end
        fields_in = '0;
        base = cap_n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (cap_n != base) begin errors++; $display("FAIL rstmid_quiet got %0d strobes want 0", cap_n - base); end
        base = cap_n; sbase = sent_n;
        fields_in = {10'd240, 10'd963};
        wait_sent(sbase + 1);
        checks++; if (cap_n - base != PLEN) begin errors++; $display("FAIL rstmid_len got %0d want %0d", cap_n - base, PLEN); end
        for (int i = 0; i < PLEN; i++) begin
            checks++;
            if (cap_mem[base+i] !== exp_rst[i]) begin
                errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, cap_mem[base+i], exp_rst[i]);
            end
        end
    endtask

    task automatic test_no_write_while_busy();
        checks++;
        if (wr_viol != 0) begin errors++; $display("FAIL wr_while_busy got %0d strobes want 0", wr_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_late_busy();
        test_force_busy();
        test_change_during();
        test_heartbeat();
        test_reset_mid();
        test_no_write_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
